// File: rtl/mem_pkg.sv
// Shared types and helpers for the init-sequenced register-array memory.
package mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Address width for a given depth; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Init sequencer: walks every word once after reset or clear, owning the write port while busy.
module mem_init_seq
    import mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              seq_we,
    output logic [ADDR_W-1:0] seq_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] init_ptr;
    logic [ADDR_W-1:0] init_ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_ptr <= '0;
        end else begin
            state    <= state_nxt;
            init_ptr <= init_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_ptr_nxt = init_ptr;
        seq_we       = 1'b0;
        busy         = 1'b0;
        case (state)
            INIT: begin
                seq_we = 1'b1;
                busy   = 1'b1;
                // A clear mid-sequence restarts the walk from word 0.
                if (clear) begin
                    init_ptr_nxt = '0;
                end else if (init_ptr == LAST) begin
                    init_ptr_nxt = '0;
                    state_nxt    = RUN;
                end else begin
                    init_ptr_nxt = init_ptr + ADDR_W'(1);
                end
            end
            RUN: begin
                if (clear) begin
                    state_nxt    = INIT;
                    init_ptr_nxt = '0;
                end
            end
            default: begin
                state_nxt    = INIT;
                init_ptr_nxt = '0;
            end
        endcase
    end

    assign seq_addr = init_ptr;

endmodule

// File: rtl/mem_init_ram.sv
// DEPTH x DATA_W register-array memory: one write port, one registered read port,
// hardware fill with INIT_VAL after reset or on clear.
module mem_init_ram
    import mem_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = 8'h05,
    localparam int               ADDR_W   = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              addr_err,
    output logic              busy
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              seq_we;
    logic [ADDR_W-1:0] seq_addr;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              user_we;
    logic              user_re;
    logic              oor_p0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word_p0;

    logic [DATA_W-1:0] rd_data_p1;
    logic              vld_p1;
    logic              addr_err_p1;

    mem_init_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .seq_we   (seq_we),
        .seq_addr (seq_addr),
        .busy     (busy)
    );

    // Stage p0: qualify user accesses and select the write source.
    always_comb begin
        wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
        rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
        user_we     = !busy && wr_en && wr_in_range;
        user_re     = !busy && rd_en;
        oor_p0      = !busy && ((wr_en && !wr_in_range) || (rd_en && !rd_in_range));
        mem_we      = seq_we || user_we;
        mem_waddr   = seq_we ? seq_addr : wr_addr;
        mem_wdata   = seq_we ? INIT_VAL : wr_data;
        rd_word_p0  = '0;
        if (rd_in_range) begin
            rd_word_p0 = mem[rd_addr];
        end
    end

    // Storage carries no reset; contents are defined by the init walk.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Stage p1: registered read data, valid and error strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_p1  <= '0;
            vld_p1      <= 1'b0;
            addr_err_p1 <= 1'b0;
        end else begin
            if (user_re) begin
                rd_data_p1 <= rd_word_p0;
            end
            vld_p1      <= user_re;
            addr_err_p1 <= oor_p0;
        end
    end

    assign rd_data  = rd_data_p1;
    assign rd_valid = vld_p1;
    assign addr_err = addr_err_p1;

endmodule

// File: tb/tb_mem_init_ram.sv
// Scoreboard bench for mem_init_ram: a DEPTH=5 instance for the full plan, a DEPTH=4 one for power-of-two init.
module tb_mem_init_ram;

    typedef struct packed {
        logic       rd;
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       clear = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [2:0] rd_addr = '0;
    logic [7:0] rd_data5;
    logic       rd_valid5;
    logic       addr_err5;
    logic       busy5;

    logic       rd_en4 = 1'b0;
    logic [1:0] rd_addr4 = '0;
    logic [7:0] rd_data4;
    logic       rd_valid4;
    logic       addr_err4;
    logic       busy4;

    exp_t q5[$];
    exp_t q4[$];
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mem_init_ram #(.DATA_W(8), .DEPTH(5), .INIT_VAL(8'h05)) dut5 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data5), .rd_valid(rd_valid5), .addr_err(addr_err5), .busy(busy5)
    );

    mem_init_ram #(.DATA_W(8), .DEPTH(4), .INIT_VAL(8'h05)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0),
        .wr_en(1'b0), .wr_addr(2'd0), .wr_data(8'h00),
        .rd_en(rd_en4), .rd_addr(rd_addr4),
        .rd_data(rd_data4), .rd_valid(rd_valid4), .addr_err(addr_err4), .busy(busy4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    always @(negedge clk) begin
        if (rst_n && (rd_valid5 || addr_err5)) begin
            if (q5.size() == 0) begin
                chk("d5_unexpected_output", {30'd0, rd_valid5, addr_err5}, 32'd0);
            end else begin
                exp_t e;
                e = q5.pop_front();
                chk("d5_rd_valid", 32'(rd_valid5), 32'(e.rd));
                if (e.rd) chk("d5_rd_data", 32'(rd_data5), 32'(e.data));
                chk("d5_addr_err", 32'(addr_err5), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (rd_valid4 || addr_err4)) begin
            if (q4.size() == 0) begin
                chk("d4_unexpected_output", {30'd0, rd_valid4, addr_err4}, 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("d4_rd_valid", 32'(rd_valid4), 32'(e.rd));
                if (e.rd) chk("d4_rd_data", 32'(rd_data4), 32'(e.data));
                chk("d4_addr_err", 32'(addr_err4), 32'(e.err));
            end
        end
    end

    task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic re, input logic [2:0] ra, input logic clr);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; clear = clr;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp);
        q5.push_back('{1'b1, exp, 1'b0});
        drive(1'b0, 3'd0, 8'h00, 1'b1, a, 1'b0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        drive(1'b1, a, d, 1'b0, 3'd0, 1'b0);
    endtask

    // Counts edges until busy falls, optionally hammering the user ports meanwhile.
    task automatic busy_window(input int exp_n, input string nm, input logic poke);
        int n = 0;
        while (busy5 && n < 20) begin
            if (poke) begin
                wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hAA;
                rd_en = 1'b1; rd_addr = 3'd3;
            end
            @(posedge clk); #1;
            n++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk(nm, 32'(n), 32'(exp_n));
    endtask

    initial begin
        int n;
        int first4;
        int first5;
        logic [7:0] exp5 [5];

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_data", 32'(rd_data5), 32'h0);
        chk("reset_rd_valid", 32'(rd_valid5), 32'h0);
        chk("reset_addr_err", 32'(addr_err5), 32'h0);
        chk("reset_busy5", 32'(busy5), 32'h1);
        chk("reset_busy4", 32'(busy4), 32'h1);

        rst_n = 1'b1;
        n = 0; first4 = -1; first5 = -1;
        while ((busy5 || busy4) && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (!busy4 && first4 < 0) first4 = n;
            if (!busy5 && first5 < 0) first5 = n;
        end
        chk("init_window_d4", 32'(first4), 32'd4);
        chk("init_window_d5", 32'(first5), 32'd5);

        for (int i = 0; i < 4; i++) begin
            q4.push_back('{1'b1, 8'h05, 1'b0});
            rd_en4 = 1'b1; rd_addr4 = 2'(i);
            @(posedge clk); #1;
        end
        rd_en4 = 1'b0;

        for (int i = 0; i < 5; i++) rd(3'(i), 8'h05);

        wr(3'd2, 8'hA5);
        rd(3'd2, 8'hA5);
        rd(3'd1, 8'h05);

        q5.push_back('{1'b1, 8'h05, 1'b0});
        drive(1'b1, 3'd1, 8'h3C, 1'b1, 3'd1, 1'b0);
        rd(3'd1, 8'h3C);

        q5.push_back('{1'b1, 8'h00, 1'b1});
        drive(1'b1, 3'd6, 8'h77, 1'b1, 3'd7, 1'b0);
        q5.push_back('{1'b0, 8'h00, 1'b1});
        wr(3'd5, 8'h11);
        exp5 = '{8'h05, 8'h3C, 8'hA5, 8'h05, 8'h05};
        for (int i = 0; i < 5; i++) rd(3'(i), exp5[i]);

        for (int i = 0; i < 5; i++) wr(3'(i), 8'hFF);
        q5.push_back('{1'b1, 8'hFF, 1'b0});
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1);
        chk("clear_busy_rise", 32'(busy5), 32'h1);
        busy_window(5, "clear_window", 1'b1);
        for (int i = 0; i < 5; i++) rd(3'(i), 8'h05);

        wr(3'd4, 8'h99);
        rst_n = 1'b0;
        #1;
        chk("run_reset_busy", 32'(busy5), 32'h1);
        chk("run_reset_rd_data", 32'(rd_data5), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midinit_reset_busy", 32'(busy5), 32'h1);
        chk("midinit_reset_rd_valid", 32'(rd_valid5), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        busy_window(5, "reset_restart_window", 1'b1);
        for (int i = 0; i < 5; i++) rd(3'(i), 8'h05);

        repeat (3) @(posedge clk);
        #1;
        chk("d5_queue_drained", 32'(q5.size()), 32'd0);
        chk("d4_queue_drained", 32'(q4.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
